// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler.
// The optional abort path is enabled by defining DELAY_SCHED_ABORT_EN.
package delay_sched_pkg;

    localparam int CNT_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/delay_sched_if.sv
// Requester-side bundle of the delay scheduler; abort/aborted exist only
// when DELAY_SCHED_ABORT_EN is defined.
interface delay_sched_if #(
    parameter int CNT_W = delay_sched_pkg::CNT_W_DEF
);

    // Handshake: requester i raises req[i] (level) and holds it, with a stable
    // len, until it sees done[i] high for one cycle; gnt[i] marks ownership.
    logic [1:0]       req;
    logic [CNT_W-1:0] len0;
    logic [CNT_W-1:0] len1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             busy;
    logic             flag;
`ifdef DELAY_SCHED_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (output req, len0, len1, abort, input gnt, done, busy, flag, aborted);
    modport slave  (input req, len0, len1, abort, output gnt, done, busy, flag, aborted);
`else
    modport master (output req, len0, len1, input gnt, done, busy, flag);
    modport slave  (input req, len0, len1, output gnt, done, busy, flag);
`endif

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Shared delay counter granted to one of two requesters, with a registered
// IDLE/RUN/DONE FSM. Define DELAY_SCHED_ABORT_EN to add the abort path.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    delay_sched_if.slave bus,
    output state_t       dbg_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             busy_q, busy_d;
    logic             flag_q, flag_d;
    logic             last_q, last_d;
    logic [1:0]       win;
    logic             end_run;
`ifdef DELAY_SCHED_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        end_run = (cnt_q == len_q);
`ifdef DELAY_SCHED_ABORT_EN
        end_run = end_run | bus.abort;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        flag_d  = flag_q;
        last_d  = last_q;
`ifdef DELAY_SCHED_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = RUN;
                    gnt_d   = win;
                    len_d   = win[1] ? bus.len1 : bus.len0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // The counter holds on the terminal cycle so len = all-ones never wraps.
                if (end_run) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    flag_d  = ~flag_q;
                    last_d  = gnt_q[1];
`ifdef DELAY_SCHED_ABORT_EN
                    aborted_d = bus.abort;
`endif
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            flag_q  <= 1'b1;
            last_q  <= 1'b1;
`ifdef DELAY_SCHED_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
            last_q  <= last_d;
`ifdef DELAY_SCHED_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.flag  = flag_q;
    assign dbg_state = state_q;
`ifdef DELAY_SCHED_ABORT_EN
    assign bus.aborted = aborted_q;
`endif

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 10, giving the width of the delay counter and of each length input.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 2 bits: level request per requester; requester i holds req[i] high until it sees done[i].
REQ-005 The block SHALL have port len0, input, CNT_W bits: delay length for requester 0, sampled only at grant.
REQ-006 The block SHALL have port len1, input, CNT_W bits: delay length for requester 1, sampled only at grant.
REQ-007 The block SHALL have port gnt, output, 2 bits: one-hot owner of the shared counter; all zero when no owner.
REQ-008 The block SHALL have port done, output, 2 bits: one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN or DONE.
REQ-010 The block SHALL have port flag, output, 1 bit: toggles on every completed delay.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE and SHALL be registered.
REQ-012 IDLE with req==0 SHALL remain in IDLE.
REQ-013 IDLE with any req bit high at edge k SHALL move to RUN after edge k: winner gets gnt, lenX latched into len_q, counter cleared to 0.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; a single request wins outright.
REQ-015 RUN SHALL increment the counter by 1 each cycle.
REQ-016 RUN with counter==len_q SHALL move to DONE on the next edge, so RUN lasts exactly len_q+1 cycles; len_q==0 gives 1 RUN cycle; len_q==2^CNT_W-1 gives 2^CNT_W cycles without overflow.
REQ-017 DONE SHALL last 1 cycle: done[owner]=1, gnt held, flag toggled on entry, last-served pointer set to the owner; then move to IDLE.
REQ-018 Returning to IDLE SHALL clear gnt; a new grant needs at least one IDLE cycle, so the minimum grant spacing is len+3 cycles.
REQ-019 A request arriving during RUN or DONE SHALL wait; it SHALL be arbitrated in the next IDLE cycle.
REQ-020 Changes on lenX after grant SHALL be ignored.
REQ-021 done and gnt SHALL be one-hot-or-zero at all times.

Reset
REQ-022 reset_n low SHALL asynchronously force: state IDLE, gnt=0, done=0, busy=0, counter=0, len_q=0, flag=1, last-served pointer=1 (requester 0 favoured first).
REQ-023 Reset mid-RUN SHALL abandon the delay with no done pulse; after release the block SHALL behave as from power-up.

Configuration
REQ-024 With macro DELAY_SCHED_ABORT_EN defined, the block SHALL add input abort (1 bit) and output aborted (1 bit, reset 0).
REQ-025 With the macro defined, abort high in a RUN cycle SHALL force DONE on the next edge with done[owner]=1, aborted=1 for that cycle and flag toggled.
REQ-026 With the macro defined, abort in IDLE or DONE SHALL be ignored.
REQ-027 Without the macro, the abort and aborted ports and their logic SHALL be absent, and behaviour SHALL be REQ-011..REQ-021 only.

Structure
REQ-028 Package delay_sched_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the CNT_W default constant.
REQ-029 The round-robin choice SHALL be a separate sub-module rr_arb2 (inputs: req[1:0], last pointer; output: one-hot winner).
REQ-030 The counter, FSM and len_q SHALL stay in delay_sched.

Verification
REQ-031 Bench SHALL cover: reset release, req=01, len0=5 -> gnt=01 after the grant edge, busy=1, RUN 6 cycles, done=01 for 1 cycle, flag 1->0.
REQ-032 Bench SHALL cover: req=11 from reset, len0=2, len1=3 -> requester 0 served first (done[0]), then requester 1 (done[1]); with req held, grants alternate 0,1,0,1.
REQ-033 Bench SHALL cover: len1=0 and separately len1=1023 -> RUN lasts 1 and 1024 cycles, counter never wraps.
REQ-034 Bench SHALL cover: reset_n low in cycle 3 of RUN -> all outputs at reset values immediately, no done pulse.
REQ-035 Bench SHALL cover: len0 changed from 8 to 2 during RUN -> delay still 9 RUN cycles.
REQ-036 Bench SHALL cover, with DELAY_SCHED_ABORT_EN defined: abort in RUN cycle 2 of len0=10 -> DONE next cycle, done=01, aborted=1, flag toggles.
